// File: rtl/isbm_rr_if.sv
// Bus bundle between the per-port input FIFOs, the buffer manager and the output link.
// Output link handshake: a beat moves when ovalid & ordy are both high on a rising edge;
// while ordy is low the master holds ovalid, odata and otype stable.
interface isbm_rr_if #(
  parameter int NPORT = 4,
  parameter int DW    = 32
);
  localparam int GW = $clog2(NPORT);

  logic [2*NPORT-1:0]  pout;
  logic [DW*NPORT-1:0] din;
  logic [NPORT-1:0]    empty;
  logic [NPORT-1:0]    re;
  logic [DW-1:0]       odata;
  logic [1:0]          otype;
  logic                ovalid;
  logic                ordy;
  logic                busy;
  logic [GW-1:0]       gnt_id;
  logic                err;
  logic                dbg_state;
  logic [GW-1:0]       dbg_ptr;

  modport master (
    input  pout, din, empty, ordy,
    output re, odata, otype, ovalid, busy, gnt_id, err, dbg_state, dbg_ptr
  );

  modport slave (
    output pout, din, empty, ordy,
    input  re, odata, otype, ovalid, busy, gnt_id, err, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/isbm_rr.sv
// Input-side buffer manager: packet-atomic round-robin of NPORT FWFT FIFOs onto one link,
// with a per-packet length watchdog and discard of stray (non-HEAD) flits while idle.
module isbm_rr #(
  parameter int         NPORT   = 4,
  parameter int         DW      = 32,
  parameter int         MAXLEN  = 16,
  parameter logic [1:0] FT_HEAD = 2'b01,
  parameter logic [1:0] FT_TAIL = 2'b11
) (
  input logic       clk,
  input logic       rst,
  isbm_rr_if.master bus
);
  localparam int PW = $clog2(NPORT);
  localparam int CW = $clog2(MAXLEN + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t          r_state, w_state_n;
  logic [PW-1:0]   r_cur, w_cur_n;
  logic [PW-1:0]   r_ptr, w_ptr_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;

  logic [1:0]      w_cur_type;
  logic [DW-1:0]   w_cur_data;
  logic            w_cur_empty;
  logic [PW-1:0]   w_cur_inc;
  logic            w_last;
  logic            w_found;
  logic [PW-1:0]   w_winner;
  logic            w_fire;
  logic [NPORT-1:0] w_re;
  logic            w_ovalid;
  logic [1:0]      w_otype;
  logic            w_err;

  assign w_cur_type  = bus.pout[2*r_cur +: 2];
  assign w_cur_data  = bus.din[DW*r_cur +: DW];
  assign w_cur_empty = bus.empty[r_cur];
  assign w_cur_inc   = (r_cur == PW'(NPORT - 1)) ? '0 : r_cur + 1'b1;
  assign w_last      = (r_cnt == CW'(MAXLEN - 1));

  // First HEAD candidate scanning from the round-robin pointer upwards, wrapping.
  always_comb begin : p_scan
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NPORT; k++) begin
      idx = (int'(r_ptr) + k) % NPORT;
      if (!w_found && !bus.empty[idx] && (bus.pout[2*idx +: 2] == FT_HEAD)) begin
        w_found  = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  always_comb begin : p_next
    w_state_n = r_state;
    w_cur_n   = r_cur;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_re      = '0;
    w_ovalid  = 1'b0;
    w_otype   = w_cur_type;
    w_err     = 1'b0;
    w_fire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        for (int i = 0; i < NPORT; i++) begin
          if (!bus.empty[i] && (bus.pout[2*i +: 2] != FT_HEAD)) w_re[i] = 1'b1;
        end
        w_err = |w_re;
        if (w_found) begin
          w_cur_n   = w_winner;
          w_cnt_n   = '0;
          w_state_n = S_XFER;
        end
      end
      S_XFER: begin
        w_ovalid   = ~w_cur_empty;
        w_fire     = w_ovalid & bus.ordy;
        w_re[r_cur] = w_fire;
        // The truncating beat shows TAIL for as long as it is offered, not just when it moves.
        if (w_last) w_otype = FT_TAIL;
        if (w_fire) begin
          w_cnt_n = r_cnt + 1'b1;
          if (w_cur_type == FT_TAIL) begin
            w_state_n = S_IDLE;
            w_ptr_n   = w_cur_inc;
          end else if (w_last) begin
            w_err     = 1'b1;
            w_state_n = S_IDLE;
            w_ptr_n   = w_cur_inc;
          end else if ((w_cur_type == FT_HEAD) && (r_cnt != '0)) begin
            w_err = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cur   <= w_cur_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
    end
  end

  assign bus.re        = w_re;
  assign bus.ovalid    = w_ovalid;
  assign bus.odata     = w_cur_data;
  assign bus.otype     = w_otype;
  assign bus.err       = w_err;
  assign bus.busy      = (r_state == S_XFER);
  assign bus.gnt_id    = r_cur;
  assign bus.dbg_state = r_state;
  assign bus.dbg_ptr   = r_ptr;
endmodule

// File: tb/tb_isbm_rr.sv
// Bench for isbm_rr: directed scenarios plus randomized multi-port traffic checked
// against a packet-level reference model of the arbitration and discard rules.
module tb_isbm_rr;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int ML = 4;
  localparam int W  = 2 + 2 + DW;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b10;
  localparam logic [1:0] TAIL = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  isbm_rr_if #(.NPORT(NP), .DW(DW)) bus ();

  isbm_rr #(.NPORT(NP), .DW(DW), .MAXLEN(ML), .FT_HEAD(HEAD), .FT_TAIL(TAIL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW+1:0] fmem [NP][512];
  int            fhd [NP];
  int            ftl [NP];
  logic          stall;
  int            total;
  int            bad;
  logic [W-1:0]  exp_q[$];

  // ---------------- FIFO model / drivers ----------------
  task automatic drive_fifo();
    logic [DW+1:0] f;
    for (int i = 0; i < NP; i++) begin
      f = (fhd[i] != ftl[i]) ? fmem[i][fhd[i]] : '0;
      bus.empty[i]          = stall || (fhd[i] == ftl[i]);
      bus.pout[2*i +: 2]    = f[DW+1:DW];
      bus.din[DW*i +: DW]   = f[DW-1:0];
    end
  endtask

  task automatic settle();
    drive_fifo();
    #1;
  endtask

  task automatic step();
    logic [NP-1:0] r;
    drive_fifo();
    #1;
    r = bus.re;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (r[i] && fhd[i] != ftl[i]) fhd[i]++;
    drive_fifo();
    #1;
  endtask

  task automatic push(input int p, input logic [1:0] t, input logic [DW-1:0] d);
    fmem[p][ftl[p]] = {t, d};
    ftl[p]++;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NP; i++) begin
      fhd[i] = 0;
      ftl[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.ordy = 1'b1;
    stall    = 1'b0;
    clear_fifos();
    settle();
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  function automatic logic [1:0] pkt_type(input int k, input int len);
    if (k == 0) return HEAD;
    if (k == len - 1) return TAIL;
    return BODY;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%0b want=0", bus.ovalid); end
    total++; if (bus.re !== 4'b0000) begin bad++; $display("FAIL reset_re got=%b want=0000", bus.re); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", bus.err); end
    total++; if (bus.gnt_id !== 2'd0) begin bad++; $display("FAIL reset_gnt got=%0d want=0", bus.gnt_id); end
    total++; if (bus.dbg_ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d want=0", bus.dbg_ptr); end
  endtask

  task automatic test_single();
    logic [DW-1:0] d [4];
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      push(2, pkt_type(k, 4), d[k]);
    end
    settle();
    total++; if (bus.ovalid !== 1'b0 || bus.re !== 4'b0000) begin
      bad++; $display("FAIL single_idle ovalid=%0b re=%b want 0/0000", bus.ovalid, bus.re);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({bus.ovalid, bus.gnt_id, bus.re, bus.err} !== {1'b1, 2'd2, 4'b0100, 1'b0}) begin
        bad++; $display("FAIL single_ctl beat=%0d got v=%0b g=%0d re=%b e=%0b want 1/2/0100/0",
                        k, bus.ovalid, bus.gnt_id, bus.re, bus.err);
      end
      total++;
      if ({bus.otype, bus.odata} !== {pkt_type(k, 4), d[k]}) begin
        bad++; $display("FAIL single_beat beat=%0d got %0d/%h want %0d/%h",
                        k, bus.otype, bus.odata, pkt_type(k, 4), d[k]);
      end
      step();
    end
    total++; if (bus.busy !== 1'b0 || bus.ovalid !== 1'b0) begin
      bad++; $display("FAIL single_end busy=%0b ovalid=%0b want 0/0", bus.busy, bus.ovalid);
    end
    total++; if (bus.dbg_ptr !== 2'd3) begin bad++; $display("FAIL single_ptr got=%0d want=3", bus.dbg_ptr); end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] pd [4][3];
    int pp [4];
    pp[0] = 0; pp[1] = 3; pp[2] = 0; pp[3] = 3;
    do_reset();
    for (int p = 0; p < 4; p++) for (int k = 0; k < 3; k++) pd[p][k] = $urandom;
    for (int k = 0; k < 3; k++) push(0, pkt_type(k, 3), pd[0][k]);
    for (int k = 0; k < 3; k++) push(0, pkt_type(k, 3), pd[2][k]);
    for (int k = 0; k < 3; k++) push(3, pkt_type(k, 3), pd[1][k]);
    for (int k = 0; k < 3; k++) push(3, pkt_type(k, 3), pd[3][k]);
    settle();
    for (int p = 0; p < 4; p++) begin
      total++; if (bus.busy !== 1'b0 || bus.ovalid !== 1'b0) begin
        bad++; $display("FAIL rr_gap pkt=%0d busy=%0b ovalid=%0b want 0/0", p, bus.busy, bus.ovalid);
      end
      step();
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({bus.ovalid, bus.gnt_id, bus.otype, bus.odata} !== {1'b1, 2'(pp[p]), pkt_type(k, 3), pd[p][k]}) begin
          bad++; $display("FAIL rr_beat pkt=%0d beat=%0d got v=%0b g=%0d t=%0d d=%h want 1/%0d/%0d/%h",
                          p, k, bus.ovalid, bus.gnt_id, bus.otype, bus.odata, pp[p], pkt_type(k, 3), pd[p][k]);
        end
        step();
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d [4];
    int k;
    logic exp_v;
    for (int j = 0; j < 4; j++) begin
      d[j] = $urandom;
      push(1, pkt_type(j, 4), d[j]);
    end
    settle();
    step();
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      bus.ordy = !(c == 1 || c == 2);
      stall    = (c == 4 || c == 5);
      settle();
      exp_v = !stall;
      total++; if (bus.ovalid !== exp_v) begin
        bad++; $display("FAIL bp_valid cyc=%0d got=%0b want=%0b", c, bus.ovalid, exp_v);
      end
      if (exp_v) begin
        total++;
        if ({bus.otype, bus.odata} !== {pkt_type(k, 4), d[k]}) begin
          bad++; $display("FAIL bp_beat cyc=%0d got %0d/%h want %0d/%h", c, bus.otype, bus.odata, pkt_type(k, 4), d[k]);
        end
        total++;
        if (bus.re !== (bus.ordy ? 4'b0010 : 4'b0000)) begin
          bad++; $display("FAIL bp_re cyc=%0d got=%b want=%b", c, bus.re, bus.ordy ? 4'b0010 : 4'b0000);
        end
        if (bus.ordy) k++;
      end else begin
        total++; if (bus.re !== 4'b0000) begin bad++; $display("FAIL bp_re_stall cyc=%0d got=%b want=0000", c, bus.re); end
      end
      step();
    end
    bus.ordy = 1'b1;
    stall    = 1'b0;
    settle();
    total++; if (k != 4) begin bad++; $display("FAIL bp_count got=%0d want=4", k); end
    total++; if (bus.ovalid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL bp_end ovalid=%0b busy=%0b want 0/0", bus.ovalid, bus.busy);
    end
  endtask

  task automatic test_watchdog();
    logic [DW-1:0] d [7];
    logic [1:0] et;
    for (int j = 0; j < 7; j++) begin
      d[j] = $urandom;
      push(0, (j == 0) ? HEAD : BODY, d[j]);
    end
    settle();
    step();
    for (int j = 0; j < ML; j++) begin
      et = (j == 0) ? HEAD : ((j == ML - 1) ? TAIL : BODY);
      total++;
      if ({bus.ovalid, bus.re, bus.otype, bus.odata, bus.err} !== {1'b1, 4'b0001, et, d[j], 1'(j == ML - 1)}) begin
        bad++; $display("FAIL wd_beat beat=%0d got v=%0b re=%b t=%0d d=%h e=%0b want 1/0001/%0d/%h/%0b",
                        j, bus.ovalid, bus.re, bus.otype, bus.odata, bus.err, et, d[j], j == ML - 1);
      end
      step();
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if ({bus.busy, bus.ovalid, bus.re, bus.err} !== {1'b0, 1'b0, 4'b0001, 1'b1}) begin
        bad++; $display("FAIL wd_discard n=%0d got busy=%0b v=%0b re=%b e=%0b want 0/0/0001/1",
                        j, bus.busy, bus.ovalid, bus.re, bus.err);
      end
      step();
    end
    total++; if (bus.re !== 4'b0000 || bus.err !== 1'b0) begin
      bad++; $display("FAIL wd_quiet re=%b err=%0b want 0000/0", bus.re, bus.err);
    end
  endtask

  task automatic test_stray();
    logic [DW-1:0] d [3];
    push(1, BODY, $urandom);
    for (int j = 0; j < 3; j++) begin
      d[j] = $urandom;
      push(0, pkt_type(j, 3), d[j]);
    end
    settle();
    total++;
    if ({bus.re, bus.err, bus.busy, bus.ovalid} !== {4'b0010, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL stray_idle got re=%b e=%0b busy=%0b v=%0b want 0010/1/0/0", bus.re, bus.err, bus.busy, bus.ovalid);
    end
    step();
    for (int j = 0; j < 3; j++) begin
      total++;
      if ({bus.ovalid, bus.gnt_id, bus.re, bus.err, bus.otype, bus.odata} !==
          {1'b1, 2'd0, 4'b0001, 1'b0, pkt_type(j, 3), d[j]}) begin
        bad++; $display("FAIL stray_beat beat=%0d got v=%0b g=%0d re=%b e=%0b t=%0d d=%h want 1/0/0001/0/%0d/%h",
                        j, bus.ovalid, bus.gnt_id, bus.re, bus.err, bus.otype, bus.odata, pkt_type(j, 3), d[j]);
      end
      step();
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stray_end busy=%0b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d [5];
    logic [DW-1:0] a [2];
    logic [DW-1:0] b [2];
    for (int j = 0; j < 5; j++) begin
      d[j] = $urandom;
      push(2, pkt_type(j, 5), d[j]);
    end
    settle();
    step();
    for (int j = 0; j < 2; j++) begin
      total++;
      if ({bus.ovalid, bus.gnt_id, bus.odata} !== {1'b1, 2'd2, d[j]}) begin
        bad++; $display("FAIL rstmid_beat beat=%0d got v=%0b g=%0d d=%h want 1/2/%h", j, bus.ovalid, bus.gnt_id, bus.odata, d[j]);
      end
      step();
    end
    bus.ordy = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    bus.ordy = 1'b1;
    settle();
    total++;
    if ({bus.busy, bus.ovalid, bus.gnt_id, bus.dbg_ptr} !== {1'b0, 1'b0, 2'd0, 2'd0}) begin
      bad++; $display("FAIL rstmid_state got busy=%0b v=%0b g=%0d ptr=%0d want 0/0/0/0", bus.busy, bus.ovalid, bus.gnt_id, bus.dbg_ptr);
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if ({bus.re, bus.err, bus.ovalid} !== {4'b0100, 1'b1, 1'b0}) begin
        bad++; $display("FAIL rstmid_discard n=%0d got re=%b e=%0b v=%0b want 0100/1/0", j, bus.re, bus.err, bus.ovalid);
      end
      step();
    end
    total++; if (bus.re !== 4'b0000 || bus.err !== 1'b0) begin
      bad++; $display("FAIL rstmid_quiet re=%b err=%0b want 0000/0", bus.re, bus.err);
    end
    for (int j = 0; j < 2; j++) begin
      a[j] = $urandom; push(1, pkt_type(j, 2), a[j]);
      b[j] = $urandom; push(3, pkt_type(j, 2), b[j]);
    end
    settle();
    step();
    for (int j = 0; j < 2; j++) begin
      total++;
      if ({bus.ovalid, bus.gnt_id, bus.otype, bus.odata} !== {1'b1, 2'd1, pkt_type(j, 2), a[j]}) begin
        bad++; $display("FAIL rstmid_next1 beat=%0d got v=%0b g=%0d t=%0d d=%h want 1/1/%0d/%h",
                        j, bus.ovalid, bus.gnt_id, bus.otype, bus.odata, pkt_type(j, 2), a[j]);
      end
      step();
    end
    step();
    for (int j = 0; j < 2; j++) begin
      total++;
      if ({bus.ovalid, bus.gnt_id, bus.otype, bus.odata} !== {1'b1, 2'd3, pkt_type(j, 2), b[j]}) begin
        bad++; $display("FAIL rstmid_next3 beat=%0d got v=%0b g=%0d t=%0d d=%h want 1/3/%0d/%h",
                        j, bus.ovalid, bus.gnt_id, bus.otype, bus.odata, pkt_type(j, 2), b[j]);
      end
      step();
    end
  endtask

  // Packet-level model: every idle step discards non-HEAD heads, grants the first HEAD
  // from the pointer, and the grant then drains a whole packet (TAIL or MAXLEN beats).
  task automatic test_random();
    int mh [NP];
    int mptr, exp_err, err_seen, w, n, idx, len;
    logic found, disc, done, timed_out;
    logic [DW+1:0] f;
    logic [1:0] t;
    logic [W-1:0] obs, e;
    for (int round = 0; round < 6; round++) begin
      do_reset();
      for (int p = 0; p < NP; p++) begin
        for (int pk = $urandom_range(0, 3); pk > 0; pk--) begin
          if ($urandom_range(0, 3) == 0) push(p, ($urandom_range(0, 1) != 0) ? BODY : TAIL, $urandom);
          len = $urandom_range(2, 6);
          for (int k = 0; k < len; k++) begin
            t = pkt_type(k, len);
            if (t == BODY && $urandom_range(0, 7) == 0) t = HEAD;
            push(p, t, $urandom);
          end
        end
      end
      exp_q.delete();
      mptr = 0; exp_err = 0;
      for (int p = 0; p < NP; p++) mh[p] = 0;
      for (int guard = 0; guard < 1000; guard++) begin
        found = 1'b0; w = 0;
        for (int k = 0; k < NP; k++) begin
          idx = (mptr + k) % NP;
          if (!found && mh[idx] < ftl[idx] && fmem[idx][mh[idx]][DW+1:DW] == HEAD) begin
            found = 1'b1; w = idx;
          end
        end
        disc = 1'b0;
        for (int i = 0; i < NP; i++) begin
          if (mh[i] < ftl[i] && fmem[i][mh[i]][DW+1:DW] != HEAD) begin
            mh[i]++; disc = 1'b1;
          end
        end
        if (disc) exp_err++;
        if (!found && !disc) break;
        if (found) begin
          n = 0;
          while (mh[w] < ftl[w]) begin
            f = fmem[w][mh[w]];
            mh[w]++; n++;
            t = f[DW+1:DW];
            if (t == TAIL) begin
              exp_q.push_back({2'(w), TAIL, f[DW-1:0]}); break;
            end else if (n == ML) begin
              exp_q.push_back({2'(w), TAIL, f[DW-1:0]}); exp_err++; break;
            end else begin
              exp_q.push_back({2'(w), t, f[DW-1:0]});
              if (t == HEAD && n > 1) exp_err++;
            end
          end
          mptr = (w + 1) % NP;
        end
      end
      err_seen = 0; timed_out = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        bus.ordy = ($urandom_range(0, 3) != 0);
        stall    = ($urandom_range(0, 7) == 0);
        settle();
        if (bus.err === 1'b1) err_seen++;
        if (bus.ovalid === 1'b1 && bus.ordy) begin
          obs = {bus.gnt_id, bus.otype, bus.odata};
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rnd_extra round=%0d got=%h want=none", round, obs);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin bad++; $display("FAIL rnd_beat round=%0d got=%h want=%h", round, obs, e); end
            total++;
            if (bus.re !== (4'b0001 << e[W-1:W-2])) begin
              bad++; $display("FAIL rnd_re round=%0d got=%b want port %0d", round, bus.re, e[W-1:W-2]);
            end
          end
        end
        done = (bus.busy === 1'b0);
        for (int i = 0; i < NP; i++) if (fhd[i] != ftl[i]) done = 1'b0;
        if (done) begin timed_out = 1'b0; break; end
        step();
      end
      stall = 1'b0; bus.ordy = 1'b1;
      settle();
      total++; if (timed_out) begin bad++; $display("FAIL rnd_timeout round=%0d got=stuck want=drained", round); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_missing round=%0d got=%0d left want=0", round, exp_q.size()); end
      total++; if (err_seen != exp_err) begin bad++; $display("FAIL rnd_err round=%0d got=%0d want=%0d", round, err_seen, exp_err); end
      total++; if (bus.dbg_ptr !== 2'(mptr)) begin bad++; $display("FAIL rnd_ptr round=%0d got=%0d want=%0d", round, bus.dbg_ptr, mptr); end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    bus.ordy = 1'b1;
    clear_fifos();
    drive_fifo();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_stray();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/isbm_rr.md
# isbm_rr

Parametrised input-side buffer manager for the switch. It arbitrates NPORT first-word-fall-through input FIFOs onto one output link using packet-atomic round-robin. Each transfer runs from HEAD to TAIL, with stall on FIFO underrun and on downstream backpressure. A per-packet length watchdog and stray-flit discard keep a malformed stream from locking the link. It sits between the per-port input FIFOs and the crossbar/output link, and replaces the single-channel ack-driven manager.

## Interface
- NPORT, 4: number of input FIFOs (≥2).
- DW, 32: flit payload width.
- MAXLEN, 16: maximum beats per packet, including HEAD and TAIL (≥2).
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pout  in  2*NPORT  flit type at each FIFO head; port i is bits [2i+1:2i]. Codes are `HEAD/`BODY/`TAIL from sw.vh.
- din  in  DW*NPORT  flit payload at each FIFO head; port i is bits [DW*i+DW-1:DW*i].
- empty  in  NPORT  per-FIFO empty flag.
- re  out  NPORT  per-FIFO read enable, one pop per asserted cycle.
- odata  out  DW  output payload.
- otype  out  2  output flit type.
- ovalid  out  1  output beat valid.
- ordy  in  1  downstream ready; a beat transfers when ovalid & ordy.
- busy  out  1  high while in XFER.
- gnt_id  out  $clog2(NPORT)  index of the currently granted port.
- err  out  1  one-cycle pulse on a stray-flit discard, a watchdog truncation, or a HEAD inside a packet.

## Operation
- State machine with states IDLE and XFER.
- Registers:
  - state
  - cur (granted port)
  - ptr (round-robin start)
  - cnt (beats sent, $clog2(MAXLEN+1) bits)
- IDLE:
  - A port is a candidate when ~empty[i] and pout[i]==`HEAD.
  - Winner is the first candidate scanning ptr, ptr+1, … modulo NPORT.
  - If a winner exists: cur=winner, cnt=0, next state XFER. No pop happens in this cycle.
  - In the same cycle, every port with ~empty[i] and pout[i]!=`HEAD gets re[i]=1 (discard). err=1 if any port is discarded.
  - ovalid=0. busy=0.
- XFER:
  - ovalid = ~empty[cur]; odata = din[cur]; otype = pout[cur]; re[cur] = ovalid & ordy.
  - All other re are 0. No discard happens in XFER.
  - On each transferred beat, cnt increments.
  - If the transferred beat has type `TAIL: next state IDLE, ptr = cur+1 (mod NPORT).
  - Else if cnt+1==MAXLEN: otype is forced to `TAIL on that beat, err=1, next state IDLE, ptr = cur+1. The remainder of the packet is then discarded as stray flits.
  - `HEAD seen in XFER: the beat is forwarded unchanged and err=1.
  - FIFO underrun (empty[cur]) mid-packet: ovalid=0, state is held, cnt is held. There is no timeout.
- gnt_id = cur, held after the packet ends until the next grant.
- odata/otype are don't-care while ovalid=0, but must not be X in simulation; drive din[cur]/pout[cur].

## Timing
- Reset values:
  - state=IDLE, ptr=0, cur=0, cnt=0.
  - re=0, ovalid=0, busy=0, err=0, gnt_id=0.
  - odata and otype follow din[0]/pout[0] gated by ovalid=0.
- re, ovalid, odata, otype and err are combinational from state and inputs. Grant and state changes are registered.
- Latency: HEAD visible at a FIFO head in cycle t while IDLE → ovalid=1 in cycle t+1.
- Between packets there is at least one IDLE cycle: TAIL transfers in t, next HEAD beat is earliest at t+2.
- Throughput: one beat per cycle while ordy=1 and the FIFO stays non-empty.
- Simultaneous candidates: exactly one is granted. The others wait, and their heads are not popped.
- ordy low: ovalid stays high, odata/otype stay stable, re=0.
- rst asserted mid-packet: returns to IDLE the next cycle. The leftover flits are discarded as stray, one per cycle per port, each with an err pulse.
- ptr wraps from NPORT-1 to 0.

## Test plan
1. Single packet, NPORT=4: port 2 holds HEAD, BODY, BODY, TAIL; ordy=1 → ovalid high for 4 consecutive cycles starting 1 cycle after the HEAD appears, gnt_id=2, re[2] pulses 4 times, next ptr=3, err never set.
2. Round-robin fairness: ports 0 and 3 each hold two 3-flit packets; ptr=0 → grant order 0,3,0,3, each packet contiguous, one IDLE cycle between packets.
3. Backpressure and underrun: ordy toggles 1,0,0,1 and port 1 goes empty for 2 cycles mid-packet → no beat lost or duplicated, odata stable while ordy=0, ovalid=0 during underrun, TAIL delivered last.
4. Watchdog, MAXLEN=4: port 0 holds HEAD plus 6 BODY flits → 4 beats out, the 4th with otype=`TAIL and err=1; the following 3 BODY flits are discarded in IDLE with 3 err pulses and ovalid=0.
5. Stray head flit: port 1 head is `BODY while port 0 holds a valid packet, in the same IDLE cycle → re[1]=1 and err=1 in that cycle, port 0 is granted, and its packet goes out intact.
6. Reset mid-packet: assert rst for 1 cycle after the 2nd beat of a 5-flit packet → all outputs return to reset values the next cycle; the 3 remaining flits are discarded; the next HEAD is granted normally with ptr=0.
